// File: rtl/bfu_pipe_pkg.sv
// Shared NTT package: default field parameters, butterfly mode encoding and the
// single-correction modular add/sub/half helpers used by the butterfly datapath.
package bfu_pipe_pkg;

   localparam int unsigned NTT_DATA_WIDTH = 12;
   localparam int unsigned NTT_Q          = 3329;
   localparam int unsigned NTT_MUL_LAT    = 4;
   localparam int unsigned HALF_Q         = (NTT_Q + 1) / 2;

   typedef enum logic [1:0] {
      MODE_CT     = 2'd0,
      MODE_GS     = 2'd1,
      MODE_PWM    = 2'd2,
      MODE_BYPASS = 2'd3
   } bfu_mode_e;

   // Helpers work on a wide container so any DATA_WIDTH/Q pair can share them.
   localparam int unsigned ARITH_W = 32;
   typedef logic [ARITH_W-1:0] arith_t;

   function automatic arith_t mod_add(input arith_t a, input arith_t b, input arith_t q);
      arith_t s;
      s = a + b;
      return (s >= q) ? s - q : s;
   endfunction

   function automatic arith_t mod_sub(input arith_t a, input arith_t b, input arith_t q);
      return (a >= b) ? a - b : a + q - b;
   endfunction

   // Odd x: (x+q)/2 == (x-1)/2 + (q+1)/2, which never overflows the operand width.
   function automatic arith_t mod_half(input arith_t x, input arith_t q);
      return x[0] ? (x >> 1) + ((q + 1) >> 1) : (x >> 1);
   endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// Pipelined modular multiplier p = a*b mod Q with fixed latency MUL_LAT; a product
// register feeds a Barrett reduction, followed by plain delay stages. Holds when en = 0.
module mod_mul_pipe #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned Q          = 3329,
   parameter int unsigned MUL_LAT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] p
);

   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam int unsigned K  = 2 * DATA_WIDTH;
   localparam logic [K:0] BARRETT_M = (K + 1)'((64'd1 << K) / 64'(Q));

   // Barrett estimate is at most two below the true quotient, hence two corrections.
   function automatic logic [DATA_WIDTH-1:0] reduce(input logic [PW-1:0] x);
      logic [PW+K:0] t;
      logic [PW:0]   qh;
      logic [PW+1:0] r;
      t  = (PW + K + 1)'(x) * (PW + K + 1)'(BARRETT_M);
      qh = (PW + 1)'(t >> K);
      r  = (PW + 2)'(x) - (PW + 2)'(qh) * (PW + 2)'(Q);
      if (r >= (PW + 2)'(Q)) r = r - (PW + 2)'(Q);
      if (r >= (PW + 2)'(Q)) r = r - (PW + 2)'(Q);
      return r[DATA_WIDTH-1:0];
   endfunction

   logic [PW-1:0] prod;
   assign prod = PW'(a) * PW'(b);

   if (MUL_LAT == 1) begin : g_single
      logic [DATA_WIDTH-1:0] p_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            p_q <= '0;
         end else if (en) begin
            p_q <= reduce(prod);
         end
      end

      assign p = p_q;
   end else begin : g_multi
      logic [PW-1:0]         prod_q;
      logic [DATA_WIDTH-1:0] red_q [MUL_LAT-1];

      // NOTE: the delay stages are plain flops, so they take the async reset like any
      // other register; nothing here is inferred as a RAM.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            prod_q <= '0;
            for (int i = 0; i < int'(MUL_LAT) - 1; i++) red_q[i] <= '0;
         end else if (en) begin
            prod_q   <= prod;
            red_q[0] <= reduce(prod_q);
            for (int i = 1; i < int'(MUL_LAT) - 1; i++) red_q[i] <= red_q[i-1];
         end
      end

      assign p = red_q[MUL_LAT-2];
   end

endmodule

// File: rtl/bfu_pipe.sv
// Unified NTT/INTT butterfly (CT, GS with halving, pointwise multiply, bypass) with a
// fixed MUL_LAT+3 cycle latency in every mode, per-stage valid/mode tags and a global stall.
module bfu_pipe
   import bfu_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = NTT_DATA_WIDTH,
   parameter int unsigned Q          = NTT_Q,
   parameter int unsigned MUL_LAT    = NTT_MUL_LAT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] u,
   input  logic [DATA_WIDTH-1:0] v,
   input  logic [DATA_WIDTH-1:0] w,
   input  logic                  stall,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] bf_upper,
   output logic [DATA_WIDTH-1:0] bf_lower,
   output logic                  busy
);

   localparam arith_t QA = arith_t'(Q);

   function automatic logic [DATA_WIDTH-1:0] add_q(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
      return DATA_WIDTH'(mod_add(arith_t'(a), arith_t'(b), QA));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sub_q(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
      return DATA_WIDTH'(mod_sub(arith_t'(a), arith_t'(b), QA));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] half_q(input logic [DATA_WIDTH-1:0] x);
      return DATA_WIDTH'(mod_half(arith_t'(x), QA));
   endfunction

   logic en;
   assign en = ~stall;

   // Input register.
   logic                  s0_valid;
   bfu_mode_e             s0_mode;
   logic [DATA_WIDTH-1:0] s0_u, s0_v, s0_w;

   // NOTE: every clocked block uses non-blocking assignments so all stages advance together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_mode  <= MODE_CT;
         s0_u     <= '0;
         s0_v     <= '0;
         s0_w     <= '0;
      end else if (en) begin
         s0_valid <= in_valid;
         s0_mode  <= bfu_mode_e'(mode);
         s0_u     <= u;
         s0_v     <= v;
         s0_w     <= w;
      end
   end

   // Add/sub stage: GS forms u+v and u-v here; other modes just pass u and v through.
   logic                  s1_valid;
   bfu_mode_e             s1_mode;
   logic [DATA_WIDTH-1:0] s1_x, s1_y, s1_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= MODE_CT;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_w     <= '0;
      end else if (en) begin
         s1_valid <= s0_valid;
         s1_mode  <= s0_mode;
         s1_x     <= (s0_mode == MODE_GS) ? add_q(s0_u, s0_v) : s0_u;
         s1_y     <= (s0_mode == MODE_GS) ? sub_q(s0_u, s0_v) : s0_v;
         s1_w     <= s0_w;
      end
   end

   // One multiplier shared by CT (v*w), GS ((u-v)*w) and PWM (v*w).
   logic [DATA_WIDTH-1:0] mul_p;

   mod_mul_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q          (Q),
      .MUL_LAT    (MUL_LAT)
   ) u_mul (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (s1_y),
      .b   (s1_w),
      .p   (mul_p)
   );

   // Delay lines carrying the tags and the non-multiplied operands alongside the multiplier.
   logic [MUL_LAT-1:0]    dl_valid;
   bfu_mode_e             dl_mode [MUL_LAT];
   logic [DATA_WIDTH-1:0] dl_x    [MUL_LAT];
   logic [DATA_WIDTH-1:0] dl_y    [MUL_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_valid <= '0;
         for (int i = 0; i < int'(MUL_LAT); i++) begin
            dl_mode[i] <= MODE_CT;
            dl_x[i]    <= '0;
            dl_y[i]    <= '0;
         end
      end else if (en) begin
         dl_valid[0] <= s1_valid;
         dl_mode[0]  <= s1_mode;
         dl_x[0]     <= s1_x;
         dl_y[0]     <= s1_y;
         for (int i = 1; i < int'(MUL_LAT); i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_mode[i]  <= dl_mode[i-1];
            dl_x[i]     <= dl_x[i-1];
            dl_y[i]     <= dl_y[i-1];
         end
      end
   end

   // Final combine: CT does its add/sub after the multiply, GS halves both results.
   logic [DATA_WIDTH-1:0] upper_n, lower_n;
   logic [DATA_WIDTH-1:0] tail_x, tail_y;
   bfu_mode_e             tail_mode;

   assign tail_x    = dl_x[MUL_LAT-1];
   assign tail_y    = dl_y[MUL_LAT-1];
   assign tail_mode = dl_mode[MUL_LAT-1];

   // NOTE: defaults first so every path assigns both results and no latch is inferred.
   always_comb begin
      upper_n = tail_x;
      lower_n = mul_p;
      case (tail_mode)
         MODE_CT: begin
            upper_n = add_q(tail_x, mul_p);
            lower_n = sub_q(tail_x, mul_p);
         end
         MODE_GS: begin
            upper_n = half_q(tail_x);
            lower_n = half_q(mul_p);
         end
         MODE_BYPASS: lower_n = tail_y;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         bf_upper  <= '0;
         bf_lower  <= '0;
      end else if (en) begin
         out_valid <= dl_valid[MUL_LAT-1];
         bf_upper  <= upper_n;
         bf_lower  <= lower_n;
      end
   end

   assign busy = s0_valid | s1_valid | (|dl_valid) | out_valid;

endmodule
